pc_npc_sequencer: RTL and testbench

PC_NPC_SEQUENCER -- requirements
Module: pc_npc_sequencer

---
 rtl/pc_npc_pkg.sv | 17 +
 rtl/pc_npc_sequencer_if.sv | 48 ++++
 rtl/npc_next_sel.sv | 37 +++
 rtl/pc_npc_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_npc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_npc_pkg.sv
// Shared types and constants for the PC/nPC sequencer.
// Holds the address width, instruction size and FSM state encoding.
package pc_npc_pkg;

    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        ANNUL,
        TRAP
    } seq_state_t;

endpackage

// File: rtl/pc_npc_sequencer_if.sv
// Control-unit <-> sequencer bundle.
// master: control unit (drives Step, Branch_Taken, Annul, Target, Trap_Req,
//         Trap_Vector, nPC); slave: sequencer (drives PC_In, nPC_In,
//         PC_Load, nPC_Load, Instr_Valid, Trap_Ack, Busy [, Align_Fault]).
// Align_Fault exists only when NPC_SEQ_ALIGN_CHECK_EN is defined.
interface pc_npc_sequencer_if;
    import pc_npc_pkg::*;

    logic  Step;
    logic  Branch_Taken;
    logic  Annul;
    addr_t Target;
    logic  Trap_Req;
    addr_t Trap_Vector;
    addr_t nPC;

    addr_t PC_In;
    addr_t nPC_In;
    logic  PC_Load;
    logic  nPC_Load;
    logic  Instr_Valid;
    logic  Trap_Ack;
    logic  Busy;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
    logic  Align_Fault;
`endif

    modport master (
        output Step, Branch_Taken, Annul, Target,
        output Trap_Req, Trap_Vector, nPC,
        input  PC_In, nPC_In, PC_Load, nPC_Load,
        input  Instr_Valid, Trap_Ack, Busy
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        , input Align_Fault
`endif
    );

    modport slave (
        input  Step, Branch_Taken, Annul, Target,
        input  Trap_Req, Trap_Vector, nPC,
        output PC_In, nPC_In, PC_Load, nPC_Load,
        output Instr_Valid, Trap_Ack, Busy
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        , output Align_Fault
`endif
    );

endinterface

// File: rtl/npc_next_sel.sv
// Combinational next-PC/nPC selection: nPC+4, branch Target or trap vector.
// Ports: npc, target, trap_vector, take_branch, take_trap in; pc_next,
// npc_next out; align_bad out only with NPC_SEQ_ALIGN_CHECK_EN.
module npc_next_sel
    import pc_npc_pkg::*;
(
    input  addr_t npc,
    input  addr_t target,
    input  addr_t trap_vector,
    input  logic  take_branch,
    input  logic  take_trap,
`ifdef NPC_SEQ_ALIGN_CHECK_EN
    output logic  align_bad,
`endif
    output addr_t pc_next,
    output addr_t npc_next
);

    localparam addr_t STEP = addr_t'(INSTR_BYTES);

    // Adders wrap modulo 2^32 by width.
    always_comb begin
        pc_next  = npc;
        npc_next = npc + STEP;
        if (take_trap) begin
            pc_next  = trap_vector;
            npc_next = trap_vector + STEP;
        end else if (take_branch) begin
            npc_next = target;
        end
    end

`ifdef NPC_SEQ_ALIGN_CHECK_EN
    assign align_bad = take_branch && (target[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_npc_sequencer.sv
// PC/nPC sequencer: INIT/RUN/ANNUL/TRAP FSM, all outputs registered on
// the falling edge of Clock with synchronous active-low Reset_n.
// Ports: Clock, Reset_n, bus (pc_npc_sequencer_if.slave).
// Optional NPC_SEQ_ALIGN_CHECK_EN: misaligned taken Target traps and
// raises Align_Fault for one cycle.
module pc_npc_sequencer
    import pc_npc_pkg::*;
#(
    parameter addr_t RESET_VECTOR = 32'h0000_0000
) (
    input  logic                Clock,
    input  logic                Reset_n,
    pc_npc_sequencer_if.slave   bus
);

    seq_state_t state_q, state_d;
    addr_t      pc_q, pc_d;
    addr_t      npc_q, npc_d;
    logic       pcl_q, pcl_d;
    logic       npcl_q, npcl_d;
    logic       iv_q, iv_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;

    logic       active;
    logic       take_branch;
    logic       trap_go;
    logic       step_go;
    addr_t      sel_pc;
    addr_t      sel_npc;

    assign active      = (state_q == RUN) || (state_q == ANNUL);
    assign take_branch = active && bus.Step && bus.Branch_Taken;

`ifdef NPC_SEQ_ALIGN_CHECK_EN
    logic align_bad;
    logic align_q, align_d;
    assign trap_go = active && (bus.Trap_Req || align_bad);
`else
    assign trap_go = active && bus.Trap_Req;
`endif

    // A trap wins over a Step in the same cycle; the Step is dropped.
    assign step_go = active && bus.Step && !trap_go;

    npc_next_sel u_sel (
        .npc         (bus.nPC),
        .target      (bus.Target),
        .trap_vector (bus.Trap_Vector),
        .take_branch (take_branch),
        .take_trap   (trap_go),
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        .align_bad   (align_bad),
`endif
        .pc_next     (sel_pc),
        .npc_next    (sel_npc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        pcl_d   = 1'b0;
        npcl_d  = 1'b0;
        iv_d    = 1'b0;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        align_d = 1'b0;
`endif
        unique case (state_q)
            INIT: begin
                pc_d    = RESET_VECTOR;
                npc_d   = RESET_VECTOR + addr_t'(INSTR_BYTES);
                pcl_d   = 1'b1;
                npcl_d  = 1'b1;
                iv_d    = 1'b1;
                state_d = RUN;
            end
            RUN, ANNUL: begin
                if (trap_go) begin
                    pc_d    = sel_pc;
                    npc_d   = sel_npc;
                    pcl_d   = 1'b1;
                    npcl_d  = 1'b1;
                    iv_d    = 1'b1;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = TRAP;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
                    align_d = align_bad;
`endif
                end else if (step_go) begin
                    pc_d   = sel_pc;
                    npc_d  = sel_npc;
                    pcl_d  = 1'b1;
                    npcl_d = 1'b1;
                    // Annul only matters when issued from RUN; the
                    // step out of ANNUL always executes.
                    if (state_q == RUN && bus.Annul) begin
                        iv_d    = 1'b0;
                        state_d = ANNUL;
                    end else begin
                        iv_d    = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            TRAP: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(negedge Clock) begin
        if (!Reset_n) begin
            state_q <= INIT;
            pc_q    <= '0;
            npc_q   <= '0;
            pcl_q   <= 1'b0;
            npcl_q  <= 1'b0;
            iv_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            pcl_q   <= pcl_d;
            npcl_q  <= npcl_d;
            iv_q    <= iv_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
            align_q <= align_d;
`endif
        end
    end

    assign bus.PC_In       = pc_q;
    assign bus.nPC_In      = npc_q;
    assign bus.PC_Load     = pcl_q;
    assign bus.nPC_Load    = npcl_q;
    assign bus.Instr_Valid = iv_q;
    assign bus.Trap_Ack    = ack_q;
    assign bus.Busy        = busy_q;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
    assign bus.Align_Fault = align_q;
`endif

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Scoreboard bench for pc_npc_sequencer (RESET_VECTOR = 0).
// Inputs change mid-cycle at the rising edge; outputs sampled there too.
module tb_pc_npc_sequencer;
    import pc_npc_pkg::*;

    typedef struct packed {
        logic  rst_n;
        logic  step;
        logic  bt;
        logic  annul;
        logic  trap;
        addr_t target;
        addr_t tv;
        addr_t npc;
    } stim_t;

    typedef struct packed {
        addr_t pc;
        addr_t npc;
        logic  pl;
        logic  nl;
        logic  iv;
        logic  ack;
        logic  busy;
        logic  align;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    pc_npc_sequencer_if bus ();

    pc_npc_sequencer #(
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input stim_t s);
        rst_n            = s.rst_n;
        bus.Step         = s.step;
        bus.Branch_Taken = s.bt;
        bus.Annul        = s.annul;
        bus.Trap_Req     = s.trap;
        bus.Target       = s.target;
        bus.Trap_Vector  = s.tv;
        bus.nPC          = s.npc;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic exp_t sample();
        exp_t o;
        o.pc    = bus.PC_In;
        o.npc   = bus.nPC_In;
        o.pl    = bus.PC_Load;
        o.nl    = bus.nPC_Load;
        o.iv    = bus.Instr_Valid;
        o.ack   = bus.Trap_Ack;
        o.busy  = bus.Busy;
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        o.align = bus.Align_Fault;
`else
        o.align = 1'b0;
`endif
        return o;
    endfunction

    task automatic test_reset();
        stim_t s[5];
        exp_t  e[5];
        exp_t  got, want;
        for (int i = 0; i < 3; i++) begin
            s[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
            e[i] = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        end
        s[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        e[3] = '{32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s[4] = s[3];
        e[4] = '{32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL reset[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    task automatic test_seq_step();
        stim_t s[2];
        exp_t  e[2];
        exp_t  got, want;
        s[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100};
        e[0] = '{32'h100, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h104};
        e[1] = '{32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL seq_step[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    task automatic test_branch_annul();
        stim_t s[4];
        exp_t  e[4];
        exp_t  got, want;
        s[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 32'h200};
        e[0] = '{32'h200, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h400};
        e[1] = '{32'h200, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        s[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h400};
        e[2] = '{32'h400, 32'h404, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h404};
        e[3] = '{32'h404, 32'h408, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL branch_annul[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    task automatic test_trap_priority();
        stim_t s[3];
        exp_t  e[3];
        exp_t  got, want;
        s[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h800, 32'h500};
        e[0] = '{32'h800, 32'h804, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h900, 32'h900};
        e[1] = '{32'h800, 32'h804, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        s[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h804};
        e[2] = e[1];
        for (int i = 0; i < 3; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL trap_priority[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    task automatic test_trap_in_annul();
        stim_t s[5];
        exp_t  e[5];
        exp_t  got, want;
        s[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h300};
        e[0] = '{32'h300, 32'h304, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hA00, 32'h304};
        e[1] = '{32'hA00, 32'hA04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA04};
        e[2] = '{32'hA00, 32'hA04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        s[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA04};
        e[3] = '{32'hA04, 32'hA08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA08};
        e[4] = '{32'hA08, 32'hA0C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL trap_in_annul[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s;
        exp_t  e;
        exp_t  got, want;
        s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC};
        e = '{32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(s);
        sb.push_back(e);
        tick();
        got  = sample();
        want = sb.pop_front();
        tests++;
        if (got !== want) begin
            $display("FAIL wrap: got %h want %h", got, want);
            fails++;
        end
    endtask

    task automatic test_mid_trap_reset();
        stim_t s[4];
        exp_t  e[4];
        exp_t  got, want;
        s[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h800, 32'h0};
        e[0] = '{32'h800, 32'h804, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h800, 32'h0};
        e[1] = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        s[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h800, 32'h0};
        e[2] = '{32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4};
        e[3] = '{32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL mid_trap_reset[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    task automatic test_align();
        stim_t s[2];
        exp_t  e[2];
        exp_t  got, want;
        s[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h402, 32'hC00, 32'h600};
        s[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
`ifdef NPC_SEQ_ALIGN_CHECK_EN
        e[0] = '{32'hC00, 32'hC04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        e[1] = '{32'hC00, 32'hC04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        e[0] = '{32'h600, 32'h402, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e[1] = '{32'h600, 32'h402, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            got  = sample();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                $display("FAIL align[%0d]: got %h want %h", i, got, want);
                fails++;
            end
        end
    endtask

    initial begin
        drive('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
        test_reset();
        test_seq_step();
        test_branch_annul();
        test_trap_priority();
        test_trap_in_annul();
        test_wrap();
        test_mid_trap_reset();
        test_align();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
